// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader, panel driver and pixel RAM:
// geometry, pixel word layout and loader state encoding.
package frame_loader_pkg;

   localparam int FRAME_WORDS = 2048;
   localparam int ADDR_W      = 12;
   localparam int HOLD_W      = 8;
   localparam int PIX_W       = 16;
   localparam int IDX_W       = ADDR_W - 1;

   // One word drives the same column in the upper and lower half of the panel.
   typedef struct packed {
      logic [3:0] rsvd;
      logic [1:0] b1;
      logic [1:0] g1;
      logic [1:0] r1;
      logic [1:0] b0;
      logic [1:0] g0;
      logic [1:0] r0;
   } pix_word_t;

   typedef enum logic {
      ST_FILL      = 1'b0,
      ST_WAIT_SWAP = 1'b1
   } load_state_t;

   function automatic pix_word_t pix_pack(input logic [1:0] r0, input logic [1:0] g0,
                                          input logic [1:0] b0, input logic [1:0] r1,
                                          input logic [1:0] g1, input logic [1:0] b1);
      pix_word_t w;
      w = '{rsvd: 4'd0, b1: b1, g1: g1, r1: r1, b0: b0, g0: g0, r0: r0};
      return w;
   endfunction

endpackage

// File: rtl/frame_loader_hold_timer.sv
// Per-image display hold counter: loads on swap, counts down once per panel
// frame and saturates at zero.
module frame_hold_timer
   import frame_loader_pkg::*;
(
   input  logic              clk_48mhz,
   input  logic              reset,
   input  logic              load_i,
   input  logic [HOLD_W-1:0] load_val_i,
   input  logic              frame_done_i,
   output logic              zero_o
);

   logic [HOLD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (frame_done_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frame_loader.sv
// Double-buffered pixel loader: fills the back RAM bank from a valid/ready
// stream and swaps banks only on a panel frame boundary once the hold expires.
module frame_loader
   import frame_loader_pkg::*;
(
   input  logic              clk_48mhz,
   input  logic              reset,
   input  logic [PIX_W-1:0]  i_pix_data,
   input  logic              i_pix_sof,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   input  logic [HOLD_W-1:0] i_hold_frames,
   input  logic              i_frame_done,
   output logic [ADDR_W-1:0] o_ram_w_addr,
   output logic [PIX_W-1:0]  o_ram_w_data,
   output logic              o_ram_w_enable,
   output logic              o_front_bank,
   output logic              o_swap
);

   load_state_t        state_q, state_d;
   logic [IDX_W-1:0]   word_idx_q, word_idx_d;
   logic               front_q, front_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]   wr_data_q, wr_data_d;
   logic               swap_q, swap_d;
   logic               hold_load;
   logic               hold_zero;
   logic               accept;
   logic [IDX_W-1:0]   wr_idx;

   frame_hold_timer u_hold (
      .clk_48mhz    (clk_48mhz),
      .reset        (reset),
      .load_i       (hold_load),
      .load_val_i   (i_hold_frames),
      .frame_done_i (i_frame_done),
      .zero_o       (hold_zero)
   );

   assign o_pix_ready = (state_q == ST_FILL);
   assign accept      = i_pix_valid && o_pix_ready;
   // sof resynchronises to the start of the bank, dropping any partial image
   assign wr_idx      = i_pix_sof ? '0 : word_idx_q;

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      front_d    = front_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      swap_d     = 1'b0;
      hold_load  = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {~front_q, wr_idx};
               wr_data_d = i_pix_data;
               if (wr_idx == IDX_W'(FRAME_WORDS - 1)) begin
                  word_idx_d = '0;
                  state_d    = ST_WAIT_SWAP;
               end else begin
                  word_idx_d = wr_idx + IDX_W'(1);
               end
            end
         end
         ST_WAIT_SWAP: begin
            if (i_frame_done && hold_zero) begin
               front_d   = ~front_q;
               swap_d    = 1'b1;
               hold_load = 1'b1;
               state_d   = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q    <= ST_FILL;
         word_idx_q <= '0;
         front_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         swap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         front_q    <= front_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         swap_q     <= swap_d;
      end
   end

   assign o_ram_w_addr   = wr_addr_q;
   assign o_ram_w_data   = wr_data_q;
   assign o_ram_w_enable = wr_en_q;
   assign o_front_bank   = front_q;
   assign o_swap         = swap_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: randomized streams against an integer-level model
// of the fill/hold/swap rules, plus directed image-level checks.
module tb_frame_loader;
   localparam int FW = 2048;

   logic        clk_48mhz = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] i_pix_data = '0;
   logic        i_pix_sof = 1'b0;
   logic        i_pix_valid = 1'b0;
   logic        o_pix_ready;
   logic [7:0]  i_hold_frames = '0;
   logic        i_frame_done = 1'b0;
   logic [11:0] o_ram_w_addr;
   logic [15:0] o_ram_w_data;
   logic        o_ram_w_enable;
   logic        o_front_bank;
   logic        o_swap;

   always #10 clk_48mhz = ~clk_48mhz;

   frame_loader dut (
      .clk_48mhz      (clk_48mhz),
      .reset          (reset),
      .i_pix_data     (i_pix_data),
      .i_pix_sof      (i_pix_sof),
      .i_pix_valid    (i_pix_valid),
      .o_pix_ready    (o_pix_ready),
      .i_hold_frames  (i_hold_frames),
      .i_frame_done   (i_frame_done),
      .o_ram_w_addr   (o_ram_w_addr),
      .o_ram_w_data   (o_ram_w_data),
      .o_ram_w_enable (o_ram_w_enable),
      .o_front_bank   (o_front_bank),
      .o_swap         (o_swap)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: image-level state held as plain integers
   bit m_wait = 0;
   int m_idx = 0, m_front = 0, m_hold = 0;
   bit m_acc;
   bit e_we, e_swap;
   int e_addr, e_data;

   // per-phase observations of the DUT write/swap stream
   int ph_writes, ph_first, ph_last, ph_swaps;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic phase_clear();
      ph_writes = 0; ph_first = -1; ph_last = -1; ph_swaps = 0;
   endtask

   task automatic step(input bit v, input bit s, input logic [15:0] d, input bit fd, input bit rst);
      int pos;
      bit swp;
      i_pix_valid  = v;
      i_pix_sof    = s;
      i_pix_data   = d;
      i_frame_done = fd;
      reset        = rst;
      check_eq("ready_pre", o_pix_ready, !m_wait);
      m_acc = 0;
      if (rst) begin
         m_wait = 0; m_idx = 0; m_front = 0; m_hold = 0;
         e_we = 0; e_swap = 0; e_addr = 0; e_data = 0;
      end else begin
         m_acc = v && !m_wait;
         swp   = m_wait && fd && (m_hold == 0);
         e_we  = m_acc;
         e_swap = swp;
         if (m_acc) begin
            pos    = s ? 0 : m_idx;
            e_addr = (1 - m_front) * FW + pos;
            e_data = d;
            if (pos == FW - 1) begin
               m_wait = 1; m_idx = 0;
            end else begin
               m_idx = pos + 1;
            end
         end
         if (swp) begin
            m_front = 1 - m_front;
            m_hold  = i_hold_frames;
            m_wait  = 0;
         end else if (fd && m_hold > 0) begin
            m_hold--;
         end
      end
      @(posedge clk_48mhz);
      #1;
      reset = 1'b0;
      check_eq("we", o_ram_w_enable, e_we);
      check_eq("swap", o_swap, e_swap);
      check_eq("front", o_front_bank, m_front);
      check_eq("ready", o_pix_ready, !m_wait);
      if (e_we || rst) begin
         check_eq("addr", o_ram_w_addr, e_addr);
         check_eq("data", o_ram_w_data, e_data);
      end
      if (o_ram_w_enable) begin
         if (ph_writes == 0) ph_first = o_ram_w_addr;
         ph_last = o_ram_w_addr;
         ph_writes++;
      end
      if (o_swap) ph_swaps++;
   endtask

   task automatic feed(input int n, input bit sof_first, input bit toggle, input bit seq,
                       input bit fd_last, input bit fd_rand);
      int sent = 0;
      int cyc = 0;
      bit ph = 1'b1;
      while (sent < n && cyc < 3 * n + 50) begin
         bit v, s, fd;
         v  = toggle ? ph : 1'b1;
         ph = !ph;
         s  = sof_first && (sent == 0);
         fd = (fd_last && v && sent == n - 1) || (fd_rand && $urandom_range(0, 199) == 0);
         step(v, s, seq ? 16'(sent) : 16'($urandom), fd, 1'b0);
         if (m_acc) begin
            if (s) check_eq("sof_addr", {21'd0, o_ram_w_addr[10:0]}, 0);
            sent++;
         end
         cyc++;
      end
      check_eq("feed_count", sent, n);
   endtask

   task automatic wait_swap(output int pulses);
      int start;
      start  = ph_swaps;
      pulses = 0;
      while (ph_swaps == start && pulses < 300) begin
         repeat (3) step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
         pulses++;
      end
      if (ph_swaps == start) check_eq("swap_timeout", 0, 1);
   endtask

   int p;

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk_48mhz);
      #1;
      check_eq("rst_ready", o_pix_ready, 1);
      check_eq("rst_front", o_front_bank, 0);
      check_eq("rst_we", o_ram_w_enable, 0);
      check_eq("rst_swap", o_swap, 0);
      check_eq("rst_addr", o_ram_w_addr, 0);
      check_eq("rst_data", o_ram_w_data, 0);
      reset = 1'b0;

      // image 1: words 0..2047 into bank 1, sof on first word
      i_hold_frames = 8'd3;
      phase_clear();
      feed(FW, 1, 0, 1, 0, 0);
      step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      check_eq("img1_writes", ph_writes, FW);
      check_eq("img1_first", ph_first, FW);
      check_eq("img1_last", ph_last, 2 * FW - 1);
      check_eq("img1_ready_low", o_pix_ready, 0);
      check_eq("img1_front_held", o_front_bank, 0);
      wait_swap(p);
      check_eq("img1_pulses", p, 1);
      check_eq("img1_swaps", ph_swaps, 1);
      check_eq("img1_front", o_front_bank, 1);

      // image 2 into bank 0; hold of 3 loaded at the first swap, no frames during fill
      i_hold_frames = 8'd2;
      phase_clear();
      feed(FW, 1, 0, 0, 0, 0);
      check_eq("img2_first", ph_first, 0);
      check_eq("img2_last", ph_last, FW - 1);
      wait_swap(p);
      check_eq("img2_pulses", p, 4);

      // sof arriving at word 700 restarts the image at the bank base
      i_hold_frames = 8'($urandom_range(0, 4));
      phase_clear();
      feed(700, 1, 0, 0, 0, 0);
      feed(FW, 1, 0, 0, 0, 0);
      check_eq("resync_writes", ph_writes, 700 + FW);
      check_eq("resync_last", ph_last, 2 * FW - 1);
      wait_swap(p);
      check_eq("resync_pulses", p, 3);

      // valid toggling with random frame_done during the fill
      phase_clear();
      feed(FW, 0, 1, 0, 0, 1);
      check_eq("toggle_writes", ph_writes, FW);
      check_eq("toggle_first", ph_first, 0);
      check_eq("toggle_last", ph_last, FW - 1);
      i_hold_frames = 8'd0;
      wait_swap(p);

      // frame_done on the same cycle as the last accepted word does not swap
      phase_clear();
      feed(FW, 1, 0, 0, 1, 0);
      step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      check_eq("late_fd_noswap", ph_swaps, 0);
      wait_swap(p);
      check_eq("late_fd_pulses", p, 1);
      check_eq("late_fd_front", o_front_bank, 1);

      // reset in the middle of a fill
      phase_clear();
      feed(1000, 1, 0, 0, 0, 0);
      step(1'b1, 1'b0, 16'hbeef, 1'b0, 1'b1);
      check_eq("mid_rst_ready", o_pix_ready, 1);
      check_eq("mid_rst_front", o_front_bank, 0);
      check_eq("mid_rst_we", o_ram_w_enable, 0);
      step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
      check_eq("mid_rst_addr", o_ram_w_addr, FW);
      check_eq("mid_rst_data", o_ram_w_data, 16'h1234);
      feed(FW - 1, 0, 0, 0, 0, 0);
      wait_swap(p);
      check_eq("mid_rst_pulses", p, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
